// File: rtl/config_mem_banked.sv
// config_mem_banked: per-core neuron configuration store.
//   Wide entries are assembled from a narrow valid/ready config bus (LSB beat
//   first) and committed in one cycle. Three 1-cycle, write-first read ports
//   serve learning params (A), neuron params + spike AER (B) and per-synapse
//   learn mode (C). Global neuron/axon counts are plain flops.
// Optional feature: define CFG_PARITY_EN to store one even-parity bit per
//   A/B/AER/axon-row entry; a parity mismatch on any read sets sticky par_err_o.
//   Without it, par_err_o is tied 0.
// Ports:
//   clk_i, rst_n_i                     clock, async active-low reset
//   cfg_valid_i/cfg_ready_o            config beat handshake
//   cfg_sel_i, cfg_addr_i, cfg_data_i  target (0=A 1=B 2=AER 3=row 4=globals), entry, payload
//   cfg_err_o                          1-cycle pulse when an entry is discarded
//   Addr_Config_A_i/rdEn_Config_A_i    -> LTP/LTD windows, rates, biasLrnMode_o
//   Addr_Config_B_i/rdEn_Config_B_i    -> neuron type/threshold fields, AERnum_o, SpikeAER_o
//   Addr_Config_C_i/rdEn_Config_C_i    {neuron,axon} -> axonLrnMode_o
//   Number_Neuron_o, Number_Axon_o     global counts
//   par_err_o                          sticky parity error
module config_mem_banked #(
    parameter int unsigned NURN_CNT_BIT_WIDTH = 8,
    parameter int unsigned AXON_CNT_BIT_WIDTH = 8,
    parameter int unsigned NUM_NURNS          = 256,
    parameter int unsigned DSIZE              = 16,
    parameter int unsigned STDP_WIN_BIT_WIDTH = 8,
    parameter int unsigned AER_BIT_WIDTH      = 32,
    parameter int unsigned CFG_BUS_WIDTH      = 32
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic                                         cfg_valid_i,
    output logic                                         cfg_ready_o,
    input  logic [2:0]                                   cfg_sel_i,
    input  logic [NURN_CNT_BIT_WIDTH-1:0]                cfg_addr_i,
    input  logic [CFG_BUS_WIDTH-1:0]                     cfg_data_i,
    output logic                                         cfg_err_o,
    input  logic [NURN_CNT_BIT_WIDTH-1:0]                Addr_Config_A_i,
    input  logic                                         rdEn_Config_A_i,
    output logic [STDP_WIN_BIT_WIDTH-1:0]                LTP_Win_o,
    output logic [STDP_WIN_BIT_WIDTH-1:0]                LTD_Win_o,
    output logic [DSIZE-1:0]                             LTP_LrnRt_o,
    output logic [DSIZE-1:0]                             LTD_LrnRt_o,
    output logic                                         biasLrnMode_o,
    input  logic [NURN_CNT_BIT_WIDTH-1:0]                Addr_Config_B_i,
    input  logic                                         rdEn_Config_B_i,
    output logic                                         NurnType_o,
    output logic                                         RandTh_o,
    output logic [DSIZE-1:0]                             Th_Mask_o,
    output logic [DSIZE-1:0]                             RstPot_o,
    output logic [DSIZE-1:0]                             FixedThreshold_o,
    output logic [3:0]                                   AERnum_o,
    output logic [AER_BIT_WIDTH-1:0]                     SpikeAER_o,
    input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_Config_C_i,
    input  logic                                         rdEn_Config_C_i,
    output logic                                         axonLrnMode_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                Number_Neuron_o,
    output logic [AXON_CNT_BIT_WIDTH-1:0]                Number_Axon_o,
    output logic                                         par_err_o
);

    localparam int unsigned WA     = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1;
    localparam int unsigned WB     = 2 + 3*DSIZE + 4;
    localparam int unsigned WAER   = AER_BIT_WIDTH;
    localparam int unsigned WROW   = 2**AXON_CNT_BIT_WIDTH;
    localparam int unsigned WG     = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
    localparam int unsigned NB_A   = (WA   + CFG_BUS_WIDTH - 1) / CFG_BUS_WIDTH;
    localparam int unsigned NB_B   = (WB   + CFG_BUS_WIDTH - 1) / CFG_BUS_WIDTH;
    localparam int unsigned NB_AER = (WAER + CFG_BUS_WIDTH - 1) / CFG_BUS_WIDTH;
    localparam int unsigned NB_ROW = (WROW + CFG_BUS_WIDTH - 1) / CFG_BUS_WIDTH;
    localparam int unsigned NB_G   = (WG   + CFG_BUS_WIDTH - 1) / CFG_BUS_WIDTH;
    localparam int unsigned NB_M1  = (NB_A  > NB_B)   ? NB_A  : NB_B;
    localparam int unsigned NB_M2  = (NB_M1 > NB_AER) ? NB_M1 : NB_AER;
    localparam int unsigned NB_M3  = (NB_M2 > NB_ROW) ? NB_M2 : NB_ROW;
    localparam int unsigned NB_MAX = (NB_M3 > NB_G)   ? NB_M3 : NB_G;
    localparam int unsigned BUF_W  = NB_MAX * CFG_BUS_WIDTH;
    localparam int unsigned CNT_W  = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;
    localparam int unsigned IDX_W  = (NUM_NURNS > 1) ? $clog2(NUM_NURNS) : 1;
    localparam int unsigned AW1    = NURN_CNT_BIT_WIDTH + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;

    localparam logic [2:0] SEL_A   = 3'd0;
    localparam logic [2:0] SEL_B   = 3'd1;
    localparam logic [2:0] SEL_AER = 3'd2;
    localparam logic [2:0] SEL_ROW = 3'd3;
    localparam logic [2:0] SEL_G   = 3'd4;

    // Index of the final beat for a target; unknown targets take a single beat.
    function automatic logic [CNT_W-1:0] last_beat(input logic [2:0] sel);
        case (sel)
            SEL_A:   last_beat = CNT_W'(NB_A - 1);
            SEL_B:   last_beat = CNT_W'(NB_B - 1);
            SEL_AER: last_beat = CNT_W'(NB_AER - 1);
            SEL_ROW: last_beat = CNT_W'(NB_ROW - 1);
            SEL_G:   last_beat = CNT_W'(NB_G - 1);
            default: last_beat = '0;
        endcase
    endfunction

    logic [1:0]                    state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [2:0]                    sel_q, sel_d;
    logic [NURN_CNT_BIT_WIDTH-1:0] addr_q, addr_d;
    logic                          bad_q, bad_d;
    logic [BUF_W-1:0]              buf_q, buf_d;
    logic                          ready_d, err_d;
    logic                          accept;

    assign accept = cfg_valid_i & cfg_ready_o;

    // Assembly FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            bad_q       <= 1'b0;
            buf_q       <= '0;
            cfg_ready_o <= 1'b0;
            cfg_err_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            bad_q       <= bad_d;
            buf_q       <= buf_d;
            cfg_ready_o <= ready_d;
            cfg_err_o   <= err_d;
        end
    end

    // Next state: collect beats, then spend one cycle committing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        bad_d   = bad_q;
        buf_d   = buf_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sel_d  = cfg_sel_i;
                    addr_d = cfg_addr_i;
                    bad_d  = (cfg_sel_i > SEL_G) || (AW1'(cfg_addr_i) >= AW1'(NUM_NURNS));
                    buf_d[CFG_BUS_WIDTH-1:0] = cfg_data_i;
                    cnt_d  = CNT_W'(1);
                    if (last_beat(cfg_sel_i) == '0) begin
                        state_d = S_COMMIT;
                        err_d   = bad_d;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    buf_d[cnt_q*CFG_BUS_WIDTH +: CFG_BUS_WIDTH] = cfg_data_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == last_beat(sel_q)) begin
                        state_d = S_COMMIT;
                        err_d   = bad_q;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d != S_COMMIT);
    end

    // Commit decode.
    logic             commit, wr_a, wr_b, wr_aer, wr_row, wr_g;
    logic [IDX_W-1:0] wr_idx;
    assign commit = (state_q == S_COMMIT) && !bad_q;
    assign wr_a   = commit && (sel_q == SEL_A);
    assign wr_b   = commit && (sel_q == SEL_B);
    assign wr_aer = commit && (sel_q == SEL_AER);
    assign wr_row = commit && (sel_q == SEL_ROW);
    assign wr_g   = commit && (sel_q == SEL_G);
    assign wr_idx = addr_q[IDX_W-1:0];

    logic [WA-1:0]   mem_a   [NUM_NURNS];
    logic [WB-1:0]   mem_b   [NUM_NURNS];
    logic [WAER-1:0] mem_aer [NUM_NURNS];
    logic [WROW-1:0] mem_row [NUM_NURNS];

    // Entry storage; not reset.
    always_ff @(posedge clk_i) begin
        if (wr_a)   mem_a[wr_idx]   <= buf_q[WA-1:0];
        if (wr_b)   mem_b[wr_idx]   <= buf_q[WB-1:0];
        if (wr_aer) mem_aer[wr_idx] <= buf_q[WAER-1:0];
        if (wr_row) mem_row[wr_idx] <= buf_q[WROW-1:0];
    end

    // Read paths with same-cycle commit bypass (write-first).
    logic [NURN_CNT_BIT_WIDTH-1:0] nurn_c_sel;
    logic [AXON_CNT_BIT_WIDTH-1:0] axon_c_sel;
    logic                          hit_a, hit_b, hit_aer, hit_row;
    logic [WA-1:0]                 rd_a;
    logic [WB-1:0]                 rd_b;
    logic [WAER-1:0]               rd_aer;
    logic [WROW-1:0]               rd_row;

    assign nurn_c_sel = Addr_Config_C_i[NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1 -: NURN_CNT_BIT_WIDTH];
    assign axon_c_sel = Addr_Config_C_i[AXON_CNT_BIT_WIDTH-1:0];
    assign hit_a   = wr_a   && (addr_q == Addr_Config_A_i);
    assign hit_b   = wr_b   && (addr_q == Addr_Config_B_i);
    assign hit_aer = wr_aer && (addr_q == Addr_Config_B_i);
    assign hit_row = wr_row && (addr_q == nurn_c_sel);
    assign rd_a    = hit_a   ? buf_q[WA-1:0]   : mem_a[Addr_Config_A_i[IDX_W-1:0]];
    assign rd_b    = hit_b   ? buf_q[WB-1:0]   : mem_b[Addr_Config_B_i[IDX_W-1:0]];
    assign rd_aer  = hit_aer ? buf_q[WAER-1:0] : mem_aer[Addr_Config_B_i[IDX_W-1:0]];
    assign rd_row  = hit_row ? buf_q[WROW-1:0] : mem_row[nurn_c_sel[IDX_W-1:0]];

    // Output registers: update on read enable, hold otherwise.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            LTP_Win_o        <= '0;
            LTD_Win_o        <= '0;
            LTP_LrnRt_o      <= '0;
            LTD_LrnRt_o      <= '0;
            biasLrnMode_o    <= 1'b0;
            NurnType_o       <= 1'b0;
            RandTh_o         <= 1'b0;
            Th_Mask_o        <= '0;
            RstPot_o         <= '0;
            FixedThreshold_o <= '0;
            AERnum_o         <= '0;
            SpikeAER_o       <= '0;
            axonLrnMode_o    <= 1'b0;
            Number_Neuron_o  <= '0;
            Number_Axon_o    <= '0;
        end else begin
            if (rdEn_Config_A_i)
                {LTP_Win_o, LTD_Win_o, LTP_LrnRt_o, LTD_LrnRt_o, biasLrnMode_o} <= rd_a;
            if (rdEn_Config_B_i) begin
                {NurnType_o, RandTh_o, Th_Mask_o, RstPot_o, FixedThreshold_o, AERnum_o} <= rd_b;
                SpikeAER_o <= rd_aer;
            end
            if (rdEn_Config_C_i)
                axonLrnMode_o <= rd_row[axon_c_sel];
            if (wr_g)
                {Number_Neuron_o, Number_Axon_o} <= buf_q[WG-1:0];
        end
    end

`ifdef CFG_PARITY_EN
    logic par_a [NUM_NURNS];
    logic par_b [NUM_NURNS];
    logic par_aer [NUM_NURNS];
    logic par_row [NUM_NURNS];
    logic rp_a, rp_b, rp_aer, rp_row, par_mis;

    // Even parity captured alongside each entry.
    always_ff @(posedge clk_i) begin
        if (wr_a)   par_a[wr_idx]   <= ^buf_q[WA-1:0];
        if (wr_b)   par_b[wr_idx]   <= ^buf_q[WB-1:0];
        if (wr_aer) par_aer[wr_idx] <= ^buf_q[WAER-1:0];
        if (wr_row) par_row[wr_idx] <= ^buf_q[WROW-1:0];
    end

    assign rp_a   = hit_a   ? ^buf_q[WA-1:0]   : par_a[Addr_Config_A_i[IDX_W-1:0]];
    assign rp_b   = hit_b   ? ^buf_q[WB-1:0]   : par_b[Addr_Config_B_i[IDX_W-1:0]];
    assign rp_aer = hit_aer ? ^buf_q[WAER-1:0] : par_aer[Addr_Config_B_i[IDX_W-1:0]];
    assign rp_row = hit_row ? ^buf_q[WROW-1:0] : par_row[nurn_c_sel[IDX_W-1:0]];
    assign par_mis = (rdEn_Config_A_i && ((^rd_a) != rp_a))
                   || (rdEn_Config_B_i && (((^rd_b) != rp_b) || ((^rd_aer) != rp_aer)))
                   || (rdEn_Config_C_i && ((^rd_row) != rp_row));

    // Sticky until reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) par_err_o <= 1'b0;
        else          par_err_o <= par_err_o | par_mis;
    end
`else
    assign par_err_o = 1'b0;
`endif

endmodule
